// File: rtl/sr_upscale_2x_writer.sv
// 2x nearest-neighbour upscaler: drains WIDTH x HEIGHT frames from the SR output FIFO
// and streams 2*WIDTH x 2*HEIGHT pixels. Optional border overlay: SR_UPSCALE_BORDER_EN.
module sr_upscale_2x_writer #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned PIXEL_WIDTH = 24,
  parameter int unsigned FIFO_THRESH = 4,
  parameter logic [PIXEL_WIDTH-1:0] BORDER_COLOR = 24'hFF0000
) (
  input  logic                   clk_w,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] fifo_dout,
  input  logic [9:0]             fifo_count,
  output logic                   fifo_rd,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned XW  = $clog2(WIDTH + 1);
  localparam int unsigned OXW = $clog2(2 * WIDTH + 1);
  localparam int unsigned YW  = $clog2(HEIGHT + 1);
  localparam int unsigned AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XW-1:0]  X_LAST  = XW'(WIDTH - 1);
  localparam logic [XW-1:0]  X_END   = XW'(WIDTH);
  localparam logic [OXW-1:0] OX_LAST = OXW'(2 * WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [9:0]     THRESH  = 10'(FIFO_THRESH);

  logic [1:0]             state, state_n;
  logic [XW-1:0]          rd_issued, rd_issued_n;
  logic [XW-1:0]          wr_ptr, wr_ptr_n;
  logic                   wr_en;
  logic [YW-1:0]          src_y, src_y_n;
  logic [OXW-1:0]         out_x, out_x_n;
  logic                   rep, rep_n;
  logic                   fifo_rd_n, out_valid_n, out_sof_n, out_eol_n, busy_n, frame_done_n;
  logic [PIXEL_WIDTH-1:0] pix_n;
  logic [AW-1:0]          rd_addr;

  logic [PIXEL_WIDTH-1:0] line_buf [WIDTH];

  // Line buffer write: FIFO data lands one cycle after its read strobe
  always_ff @(posedge clk_w) begin
    if (wr_en) line_buf[AW'(wr_ptr)] <= fifo_dout;
  end

  // Read address follows the next-beat column, so the registered read is the sync-read port
  assign rd_addr = AW'(out_x_n >> 1);

`ifdef SR_UPSCALE_BORDER_EN
  logic border_n;
  assign border_n = (out_x_n == '0) || (out_x_n == OX_LAST) ||
                    (!rep_n && (src_y_n == '0)) || (rep_n && (src_y_n == Y_LAST));
  assign pix_n = !out_valid_n ? '0 : (border_n ? BORDER_COLOR : line_buf[rd_addr]);
`else
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
  assign pix_n = out_valid_n ? line_buf[rd_addr] : '0;
`endif

  // State and registered outputs
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_issued  <= '0;
      wr_ptr     <= '0;
      wr_en      <= 1'b0;
      src_y      <= '0;
      out_x      <= '0;
      rep        <= 1'b0;
      fifo_rd    <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_pixel  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      rd_issued  <= rd_issued_n;
      wr_ptr     <= wr_ptr_n;
      wr_en      <= fifo_rd;
      src_y      <= src_y_n;
      out_x      <= out_x_n;
      rep        <= rep_n;
      fifo_rd    <= fifo_rd_n;
      out_valid  <= out_valid_n;
      out_sof    <= out_sof_n;
      out_eol    <= out_eol_n;
      out_pixel  <= pix_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    rd_issued_n = rd_issued;
    wr_ptr_n    = wr_ptr;
    src_y_n     = src_y;
    out_x_n     = out_x;
    rep_n       = rep;
    out_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (fifo_count > THRESH) begin
          state_n     = S_FILL;
          rd_issued_n = '0;
          wr_ptr_n    = '0;
        end
      end
      S_FILL: begin
        if (fifo_rd) rd_issued_n = rd_issued + XW'(1);
        if (wr_en) begin
          wr_ptr_n = wr_ptr + XW'(1);
          if (wr_ptr == X_LAST) begin
            state_n     = S_EMIT;
            out_x_n     = '0;
            rep_n       = 1'b0;
            out_valid_n = 1'b1;
          end
        end
      end
      S_EMIT: begin
        out_valid_n = 1'b1;
        if (out_valid && out_ready) begin
          if (out_x == OX_LAST) begin
            out_x_n = '0;
            if (!rep) begin
              rep_n = 1'b1;
            end else begin
              rep_n       = 1'b0;
              out_valid_n = 1'b0;
              if (src_y == Y_LAST) begin
                state_n = S_DONE;
              end else begin
                state_n     = S_FILL;
                src_y_n     = src_y + YW'(1);
                rd_issued_n = '0;
                wr_ptr_n    = '0;
              end
            end
          end else begin
            out_x_n = out_x + OXW'(1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        src_y_n = '0;
      end
      default: state_n = S_IDLE;
    endcase

    // Read decision is registered; FIFO_THRESH >= 2 covers the one-cycle lag
    fifo_rd_n    = (state_n == S_FILL) && (fifo_count > THRESH) && (rd_issued_n < X_END);
    out_sof_n    = out_valid_n && (src_y_n == '0) && !rep_n && (out_x_n == '0);
    out_eol_n    = out_valid_n && (out_x_n == OX_LAST);
    busy_n       = (state_n != S_IDLE);
    frame_done_n = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_sr_upscale_2x_writer.sv
// Directed bench for sr_upscale_2x_writer at WIDTH=4, HEIGHT=2; expected beats come from
// a vector table (border values when SR_UPSCALE_BORDER_EN is defined).
module tb_sr_upscale_2x_writer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned PW = 24;
  localparam int unsigned TH = 4;
  localparam int unsigned NB = 4 * W * H;
  localparam logic [PW-1:0] BORDER = 24'hFF0000;

  logic          clk_w, rst_n;
  logic [PW-1:0] fifo_dout;
  logic [9:0]    fifo_count;
  logic          fifo_rd;
  logic [PW-1:0] out_pixel;
  logic          out_valid, out_ready, out_sof, out_eol, busy, frame_done;

  sr_upscale_2x_writer #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .FIFO_THRESH(TH), .BORDER_COLOR(BORDER)
  ) dut (
    .clk_w(clk_w), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_count(fifo_count),
    .fifo_rd(fifo_rd), .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .frame_done(frame_done)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  // Upstream FIFO model: array of pixels, read pointer, data valid the cycle after fifo_rd
  logic [PW-1:0] src_pix [16];
  int            src_len = 0;
  int            rd_ptr = 0;
  logic          fifo_flush = 1'b1;
  logic          hold = 1'b0;

  always @(posedge clk_w) begin
    if (fifo_flush) rd_ptr <= 0;
    else if (fifo_rd) begin
      fifo_dout <= src_pix[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always_comb begin
    if (fifo_flush)            fifo_count = 10'd0;
    else if (hold)             fifo_count = 10'(TH);
    else if (rd_ptr < src_len) fifo_count = 10'd100;
    else                       fifo_count = 10'd0;
  end

  int rd_cnt = 0, done_cnt = 0, beat_cnt = 0;
  always @(negedge clk_w) if (rst_n) begin
    if (fifo_rd)    rd_cnt   <= rd_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end
  always @(posedge clk_w) if (rst_n && out_valid && out_ready) beat_cnt <= beat_cnt + 1;

  typedef struct {
    int            stall;
    logic [PW-1:0] exp_pix;
    logic          exp_sof;
    logic          exp_eol;
  } vec_t;
  vec_t vecs [NB];

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) src_pix[i] = PW'(i + 1);
    src_len    = n;
    fifo_flush = 1'b1;
    @(negedge clk_w);
    fifo_flush = 1'b0;
  endtask

  // Consume nbeats beats; offset adds to non-border pixels for later frames
  task automatic run_frame(input int off, input bit use_stall, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int w, st;
      logic [PW+1:0] held, expv;
      st = use_stall ? vecs[i].stall : 0;
      expv = {vecs[i].exp_sof, vecs[i].exp_eol,
              (vecs[i].exp_pix == BORDER) ? vecs[i].exp_pix : vecs[i].exp_pix + PW'(off)};
      w = 0;
      out_ready = (st == 0);
      while (!out_valid && w < 400) begin @(negedge clk_w); w++; end
      if (!out_valid) begin
        chk($sformatf("valid_timeout_beat%0d", i), 32'(out_valid), 32'd1);
        return;
      end
      if (!use_stall && (i % (4 * W)) != 0) chk($sformatf("bubble_beat%0d", i), 32'(w), 32'd0);
      held = {out_sof, out_eol, out_pixel};
      for (int s = 0; s < st; s++) begin
        @(negedge clk_w);
        chk($sformatf("stall_hold_beat%0d", i), 32'({out_valid, out_sof, out_eol, out_pixel}),
            32'({1'b1, held}));
      end
      out_ready = 1'b1;
      chk($sformatf("beat%0d_sof_eol_pix", i), 32'({out_sof, out_eol, out_pixel}), 32'(expv));
      @(negedge clk_w);
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 20) begin @(negedge clk_w); w++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int rd0, dn0, bt0, seen, w;

    for (int i = 0; i < int'(NB); i++) begin
      int r, c;
      r = i / (2 * W);
      c = i % (2 * W);
      vecs[i].exp_pix = PW'(W * (r / 2) + c / 2 + 1);
`ifdef SR_UPSCALE_BORDER_EN
      if (r == 0 || r == 2 * H - 1 || c == 0 || c == 2 * W - 1) vecs[i].exp_pix = BORDER;
`endif
      vecs[i].exp_sof = (i == 0);
      vecs[i].exp_eol = (c == 2 * W - 1);
      vecs[i].stall   = int'($urandom_range(0, 2));
    end

    rst_n = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk_w);
    chk("reset_outputs", 32'({out_valid, out_sof, out_eol, fifo_rd, busy, frame_done, out_pixel}), 32'd0);
    rst_n = 1'b1;
    fifo_flush = 1'b0;
    @(negedge clk_w);
    chk("idle_empty_fifo_busy", 32'({busy, fifo_rd}), 32'd0);

    // Basic frame, ready held high
    rd0 = rd_cnt; dn0 = done_cnt; bt0 = beat_cnt;
    load(8);
    run_frame(0, 1'b0, NB);
    wait_idle("basic_busy_low");
    chk("basic_fifo_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("basic_frame_done_count", 32'(done_cnt - dn0), 32'd1);
    chk("basic_beat_count", 32'(beat_cnt - bt0), 32'(NB));

    // Backpressure
    rd0 = rd_cnt; dn0 = done_cnt;
    load(8);
    run_frame(0, 1'b1, NB);
    wait_idle("bp_busy_low");
    chk("bp_fifo_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("bp_frame_done_count", 32'(done_cnt - dn0), 32'd1);

    // FIFO starvation mid-FILL
    rd0 = rd_cnt; dn0 = done_cnt;
    load(8);
    seen = 0; w = 0;
    while (seen < 2 && w < 50) begin
      @(negedge clk_w); w++;
      if (fifo_rd) seen++;
    end
    chk("starve_reads_started", 32'(seen), 32'd2);
    hold = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_w);
      chk($sformatf("starve_quiet_cyc%0d", k), 32'({fifo_rd, out_valid}), 32'd0);
    end
    hold = 1'b0;
    run_frame(0, 1'b0, NB);
    wait_idle("starve_busy_low");
    chk("starve_fifo_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("starve_frame_done_count", 32'(done_cnt - dn0), 32'd1);

    // Reset while beat 10 is presented
    load(8);
    run_frame(0, 1'b0, 10);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({out_valid, out_sof, out_eol, fifo_rd, busy, frame_done, out_pixel}), 32'd0);
    out_ready = 1'b0;
    repeat (3) @(negedge clk_w);
    rst_n = 1'b1;
    @(negedge clk_w);
    rd0 = rd_cnt; dn0 = done_cnt;
    load(8);
    run_frame(0, 1'b0, NB);
    wait_idle("post_reset_busy_low");
    chk("post_reset_fifo_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("post_reset_frame_done_count", 32'(done_cnt - dn0), 32'd1);

    // Back-to-back frames
    rd0 = rd_cnt; dn0 = done_cnt;
    load(16);
    run_frame(0, 1'b0, NB);
    out_ready = 1'b0;
    w = 0;
    while (busy && w < 10) begin @(negedge clk_w); w++; end
    chk("b2b_busy_gap", 32'(busy), 32'd0);
    chk("b2b_done_before_frame2", 32'(done_cnt - dn0), 32'd1);
    run_frame(8, 1'b0, NB);
    wait_idle("b2b_busy_low");
    chk("b2b_fifo_rd_count", 32'(rd_cnt - rd0), 32'd16);
    chk("b2b_frame_done_count", 32'(done_cnt - dn0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_upscale_2x_writer.md
Name: sr_upscale_2x_writer

Overview:
- Downstream consumer of the super-resolution output FIFO, in the write-clock domain (clk_w).
- Drains processed WIDTH x HEIGHT frames and performs 2x nearest-neighbour upscaling, so every output pixel is replicated 2 horizontally x 2 vertically.
- Emits a 2*WIDTH x 2*HEIGHT frame on a valid/ready stream with start-of-frame and end-of-line sidebands, for the display/SDRAM writer.

Parameters:
- WIDTH, 320, source pixels per line
- HEIGHT, 240, source lines per frame
- PIXEL_WIDTH, 24, bits per pixel
- FIFO_THRESH, 4, minimum FIFO occupancy before a read is issued; must be >= 2
- BORDER_COLOR, 24'hFF0000, border colour (used only with optional feature)

Ports:
- clk_w, input, 1, write-side clock
- rst_n, input, 1, reset: asynchronous, active-low
- fifo_dout, input, PIXEL_WIDTH, FIFO read data; valid the cycle after fifo_rd
- fifo_count, input, 10, FIFO read-side occupancy
- fifo_rd, output, 1, FIFO read strobe (one pixel per cycle asserted)
- out_pixel, output, PIXEL_WIDTH, upscaled pixel
- out_valid, output, 1, out_pixel valid
- out_ready, input, 1, sink accepts when out_valid && out_ready
- out_sof, output, 1, high with first pixel of frame (x=0, y=0)
- out_eol, output, 1, high with last pixel of each output row (x=2*WIDTH-1)
- busy, output, 1, high in any state other than IDLE
- frame_done, output, 1, one-cycle pulse after final pixel of frame accepted

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; line buffer contents don't-care. Reset mid-frame aborts immediately, with no partial-frame completion.
- Storage: single line buffer, WIDTH x PIXEL_WIDTH, with synchronous read.
- Counters:
  - rd_issued / wr_ptr: 0..WIDTH-1
  - src_y: 0..HEIGHT-1
  - out_x: 0..2*WIDTH-1
  - rep: 0..1, vertical repeat
- States:
  - IDLE -> FILL when fifo_count > FIFO_THRESH.
  - FILL: assert fifo_rd only while fifo_count > FIFO_THRESH and rd_issued < WIDTH.
    - Data is captured into the line buffer at wr_ptr the cycle after each fifo_rd.
    - When the WIDTH-th pixel is written -> EMIT, with rep=0 and out_x=0.
    - Stalls indefinitely on a low fifo_count; no timeout.
  - EMIT: out_pixel = line_buf[out_x>>1].
    - out_x increments on each accepted beat.
    - At out_x=2*WIDTH-1 accepted:
      - rep=0 -> rep=1, out_x=0, stay in EMIT.
      - rep=1 and src_y<HEIGHT-1 -> src_y+1, -> FILL.
      - rep=1 and src_y=HEIGHT-1 -> DONE.
  - DONE: frame_done=1 for one cycle; src_y=0 -> IDLE.
- Handshake:
  - out_pixel, out_sof and out_eol stay stable while out_valid && !out_ready.
  - out_valid never deasserts without acceptance.
  - First out_valid occurs no later than 2 cycles after entering EMIT.
  - Zero bubbles between beats while out_ready=1, including across the rep boundary.
- out_sof = (src_y==0 && rep==0 && out_x==0) on the valid beat.
- fifo_rd is never asserted outside FILL; total fifo_rd pulses per frame is exactly WIDTH*HEIGHT.
- Counter widths: $clog2 of range + 1; no wrap occurs within legal parameters.
- Output rate: at most one beat per cycle. Input has no FIFO overflow backpressure; the upstream FIFO absorbs it.

Optional Feature:
- Macro: SR_UPSCALE_BORDER_EN.
- Defined: out_pixel = BORDER_COLOR on output column 0, column 2*WIDTH-1, row 0 and row 2*HEIGHT-1; all other pixels unchanged. Timing and handshake are identical.
- Undefined: pure pass-through of replicated pixels; BORDER_COLOR is unused.

Test Plan:
- Basic frame (WIDTH=4, HEIGHT=2, out_ready=1, FIFO preloaded with pixels 1..8):
  - Output rows: 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice.
  - 32 beats total; out_sof on beat 0 only; out_eol on beats 7, 15, 23, 31.
  - frame_done pulses once; exactly 8 fifo_rd pulses.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly -> identical pixel sequence; out_pixel is unchanged on any cycle with out_valid=1 and out_ready=0.
- FIFO starvation: fifo_count held at FIFO_THRESH mid-FILL for 50 cycles -> no fifo_rd and no out_valid during the hold; resumes correctly; sequence matches the basic case.
- Reset mid-EMIT: rst_n low on beat 10 -> all outputs 0 within the same cycle (async); after release with a fresh FIFO, a full correct frame is produced with out_sof on its first beat.
- Back-to-back frames: 16 pixels preloaded -> two frames, two frame_done pulses, second out_sof after the first frame_done; busy low for at least 1 cycle between frames.
- SR_UPSCALE_BORDER_EN defined (WIDTH=4, HEIGHT=2):
  - Output rows 0 and 3 are all 24'hFF0000.
  - Rows 1 and 2 read FF0000,1,2,2,3,3,4,FF0000 and FF0000,5,6,6,7,7,8,FF0000 respectively.
